// File: rtl/id_exe_issue_pkg.sv
// Shared definitions for the ID->EX issue stage: datapath widths, ALU command
// encodings, MIPS opcode/funct constants, the decoded beat bundle and the
// immediate-extension helpers.
package id_exe_issue_pkg;

    localparam int WORD_LEN     = 32;
    localparam int EXE_CMD_LEN  = 4;
    localparam int REG_ADDR_LEN = 5;

    // ALU commands. R-type commands equal funct[3:0]; I-type commands equal
    // opcode[3:0]. 4'b1111 is never produced.
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD   = 4'b0000;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADDU  = 4'b0001;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB   = 4'b0010;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUBU  = 4'b0011;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND   = 4'b0100;
    localparam logic [EXE_CMD_LEN-1:0] EXE_OR    = 4'b0101;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XOR   = 4'b0110;
    localparam logic [EXE_CMD_LEN-1:0] EXE_NOR   = 4'b0111;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADDI  = 4'b1000;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADDIU = 4'b1001;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLT   = 4'b1010;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLTU  = 4'b1011;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ANDI  = 4'b1100;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ORI   = 4'b1101;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XORI  = 4'b1110;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL funct codes (instr[5:0]) accepted by the ALU.
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // One decoded ID/EX beat, exactly what the buffer stores and drives.
    typedef struct packed {
        logic [EXE_CMD_LEN-1:0]  exe_cmd;
        logic [WORD_LEN-1:0]     op_a;
        logic [WORD_LEN-1:0]     op_b;
        logic                    wb_en;
        logic [REG_ADDR_LEN-1:0] wb_reg;
        logic                    mem_rd;
        logic                    mem_wr;
        logic [WORD_LEN-1:0]     store_data;
        logic                    illegal;
    } issue_beat_t;

    function automatic logic [WORD_LEN-1:0] sign_ext16(input logic [15:0] imm);
        return {{(WORD_LEN-16){imm[15]}}, imm};
    endfunction

    function automatic logic [WORD_LEN-1:0] zero_ext16(input logic [15:0] imm);
        return {{(WORD_LEN-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/id_exe_issue_if.sv
// Handshake bundles on either side of the issue stage. id_exe_in_if carries
// the IF/ID beat plus register-file read data; id_exe_out_if is the ALU
// command interface toward EX. The issue stage is the slave of the first and
// the master of the second.

interface id_exe_in_if;
    import id_exe_issue_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [WORD_LEN-1:0] instr;
    logic [WORD_LEN-1:0] rs_data;
    logic [WORD_LEN-1:0] rt_data;

    modport master (
        output in_valid, instr, rs_data, rt_data,
        input  in_ready
    );

    modport slave (
        input  in_valid, instr, rs_data, rt_data,
        output in_ready
    );
endinterface

interface id_exe_out_if;
    import id_exe_issue_pkg::*;

    logic                    out_valid;
    logic                    out_ready;
    logic [EXE_CMD_LEN-1:0]  exe_cmd;
    logic [WORD_LEN-1:0]     op_a;
    logic [WORD_LEN-1:0]     op_b;
    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] wb_reg;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [WORD_LEN-1:0]     store_data;
    logic                    illegal;

    modport master (
        output out_valid, exe_cmd, op_a, op_b, wb_en, wb_reg,
               mem_rd, mem_wr, store_data, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, exe_cmd, op_a, op_b, wb_en, wb_reg,
               mem_rd, mem_wr, store_data, illegal,
        output out_ready
    );
endinterface

// File: rtl/id_exe_issue_exe_cmd_decode.sv
// Pure combinational decode of one instruction word plus its register read
// data into an issue_beat_t. Encodings mirror the execute-stage ALU decode:
// R-type commands come from funct[3:0], I-type commands from opcode[3:0].
module exe_cmd_decode
    import id_exe_issue_pkg::*;
(
    input  logic [WORD_LEN-1:0] instr,
    input  logic [WORD_LEN-1:0] rs_data,
    input  logic [WORD_LEN-1:0] rt_data,
    output issue_beat_t         beat
);

    logic [5:0]              opcode;
    logic [5:0]              funct;
    logic [REG_ADDR_LEN-1:0] rt_idx;
    logic [REG_ADDR_LEN-1:0] rd_idx;
    logic [15:0]             imm;
    logic                    is_nop;
    logic                    is_alu_r;
    logic                    is_alu_i;
    logic                    imm_zero_ext;
    logic                    unused_rs_idx;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign imm    = instr[15:0];

    // The rs index only steers the register file, which lives outside this stage.
    assign unused_rs_idx = ^instr[25:21];

    // Recognised instruction classes. The all-zero word is a NOP, not SLL.
    assign is_nop   = (instr == '0);
    assign is_alu_r = (opcode == OP_SPECIAL) &&
                      (((funct >= FN_ADD) && (funct <= FN_NOR)) ||
                       (funct == FN_SLT) || (funct == FN_SLTU));
    assign is_alu_i = (opcode >= OP_ADDI) && (opcode <= OP_XORI);

    // ANDI/ORI/XORI (opcode[3:2] == 2'b11) are logical and take a zero-extended
    // immediate; the arithmetic and compare immediates are sign-extended.
    assign imm_zero_ext = (opcode[3:2] == 2'b11);

    // Build the decoded beat; unsupported encodings collapse to an inert,
    // flagged beat so EX never sees a write-back or memory side effect.
    always_comb begin
        // NOTE: the whole bundle gets a default first so every path through the
        // if-chain assigns every field and no latch is inferred.
        beat = '0;
        if (is_nop) begin
            beat.illegal = 1'b0;
        end else if (is_alu_r) begin
            beat.exe_cmd = funct[3:0];
            beat.op_a    = rs_data;
            beat.op_b    = rt_data;
            beat.wb_reg  = rd_idx;
            beat.wb_en   = (rd_idx != '0);
        end else if (is_alu_i) begin
            beat.exe_cmd = opcode[3:0];
            beat.op_a    = rs_data;
            beat.op_b    = imm_zero_ext ? zero_ext16(imm) : sign_ext16(imm);
            beat.wb_reg  = rt_idx;
            beat.wb_en   = (rt_idx != '0);
        end else if (opcode == OP_LW) begin
            beat.exe_cmd = EXE_ADD;
            beat.op_a    = rs_data;
            beat.op_b    = sign_ext16(imm);
            beat.wb_reg  = rt_idx;
            beat.wb_en   = (rt_idx != '0);
            beat.mem_rd  = 1'b1;
        end else if (opcode == OP_SW) begin
            // Stores write no register, so wb_reg stays 0.
            beat.exe_cmd    = EXE_ADD;
            beat.op_a       = rs_data;
            beat.op_b       = sign_ext16(imm);
            beat.mem_wr     = 1'b1;
            beat.store_data = rt_data;
        end else begin
            // LUI, SPECIAL funct outside the ALU set, and every other opcode.
            beat.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_exe_issue.sv
// ID->EX issue stage: decodes the IF/ID beat and holds it in a two-entry
// registered buffer (main + skid). The main entry drives the EX outputs; the
// skid entry absorbs the one extra beat that can arrive while EX stalls,
// because in_ready is registered and only reacts a cycle later.
module id_exe_issue
    import id_exe_issue_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    id_exe_in_if.slave    up,
    id_exe_out_if.master  dn
);

    issue_beat_t dec_beat;
    issue_beat_t main_beat;
    issue_beat_t skid_beat;
    logic        main_valid;
    logic        skid_valid;
    logic        accept;
    logic        drain;
    logic        main_free;

    exe_cmd_decode u_decode (
        .instr   (up.instr),
        .rs_data (up.rs_data),
        .rt_data (up.rt_data),
        .beat    (dec_beat)
    );

    // in_ready comes straight from a flop, so out_ready never reaches it
    // combinationally; an accept therefore always finds the skid entry empty.
    assign accept    = up.in_valid & ~skid_valid;
    assign drain     = main_valid & dn.out_ready;
    assign main_free = ~main_valid | drain;

    // Occupancy flags: refill main from skid first, then from the input;
    // park the input in skid only while main is held by a stall.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            main_valid <= skid_valid | accept;
            skid_valid <= skid_valid & accept;
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    // Beat payloads follow the same routing as the flags above. A flush only
    // clears the flags; stale payload behind a cleared flag is never observed.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the payload registers are reset too, because the EX-side data
        // outputs must read 0 after reset, not whatever was last decoded.
        if (rst) begin
            main_beat <= '0;
            skid_beat <= '0;
        end else if (!flush) begin
            if (main_free) begin
                if (skid_valid) begin
                    main_beat <= skid_beat;
                    if (accept) begin
                        skid_beat <= dec_beat;
                    end
                end else if (accept) begin
                    main_beat <= dec_beat;
                end
            end else if (accept) begin
                skid_beat <= dec_beat;
            end
        end
    end

    assign up.in_ready     = ~skid_valid;

    assign dn.out_valid    = main_valid;
    assign dn.exe_cmd      = main_beat.exe_cmd;
    assign dn.op_a         = main_beat.op_a;
    assign dn.op_b         = main_beat.op_b;
    assign dn.wb_en        = main_beat.wb_en;
    assign dn.wb_reg       = main_beat.wb_reg;
    assign dn.mem_rd       = main_beat.mem_rd;
    assign dn.mem_wr       = main_beat.mem_wr;
    assign dn.store_data   = main_beat.store_data;
    assign dn.illegal      = main_beat.illegal;

endmodule

// File: tb/tb_id_exe_issue.sv
// Self-checking bench for id_exe_issue. Every accepted beat pushes its
// expected decode onto a queue; every cycle the queue head is compared with
// the EX outputs and popped when EX takes it. The queue depth also predicts
// out_valid and in_ready.
module tb_id_exe_issue;
    import id_exe_issue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    id_exe_in_if  u_in ();
    id_exe_out_if u_out ();

    id_exe_issue dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .up    (u_in),
        .dn    (u_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    issue_beat_t exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic issue_beat_t dut_beat();
        issue_beat_t b;
        b.exe_cmd    = u_out.exe_cmd;
        b.op_a       = u_out.op_a;
        b.op_b       = u_out.op_b;
        b.wb_en      = u_out.wb_en;
        b.wb_reg     = u_out.wb_reg;
        b.mem_rd     = u_out.mem_rd;
        b.mem_wr     = u_out.mem_wr;
        b.store_data = u_out.store_data;
        b.illegal    = u_out.illegal;
        return b;
    endfunction

    function automatic issue_beat_t mk(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] bb,
                                       input logic we, input logic [4:0] wr, input logic rd, input logic wr_m,
                                       input logic [31:0] sd, input logic ill);
        issue_beat_t b;
        b.exe_cmd = cmd; b.op_a = a; b.op_b = bb; b.wb_en = we; b.wb_reg = wr;
        b.mem_rd = rd; b.mem_wr = wr_m; b.store_data = sd; b.illegal = ill;
        return b;
    endfunction

    // Reference decode, written as a flat opcode/funct table.
    function automatic issue_beat_t ref_decode(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        issue_beat_t b;
        logic [31:0] sx;
        logic [31:0] zx;
        b  = '0;
        sx = {{16{i[15]}}, i[15:0]};
        zx = {16'h0000, i[15:0]};
        if (i != 32'h0) begin
            case (i[31:26])
                6'h00: begin
                    case (i[5:0])
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
                            b.exe_cmd = i[3:0]; b.op_a = rs; b.op_b = rt;
                            b.wb_reg = i[15:11]; b.wb_en = (i[15:11] != 5'd0);
                        end
                        default: b.illegal = 1'b1;
                    endcase
                end
                6'h08, 6'h09, 6'h0a, 6'h0b: begin
                    b.exe_cmd = i[29:26]; b.op_a = rs; b.op_b = sx;
                    b.wb_reg = i[20:16]; b.wb_en = (i[20:16] != 5'd0);
                end
                6'h0c, 6'h0d, 6'h0e: begin
                    b.exe_cmd = i[29:26]; b.op_a = rs; b.op_b = zx;
                    b.wb_reg = i[20:16]; b.wb_en = (i[20:16] != 5'd0);
                end
                6'h23: begin
                    b.op_a = rs; b.op_b = sx; b.wb_reg = i[20:16];
                    b.wb_en = (i[20:16] != 5'd0); b.mem_rd = 1'b1;
                end
                6'h2b: begin
                    b.op_a = rs; b.op_b = sx; b.mem_wr = 1'b1; b.store_data = rt;
                end
                default: b.illegal = 1'b1;
            endcase
        end
        return b;
    endfunction

    // One cycle: drive inputs at the falling edge, check what the last rising
    // edge produced, update the scoreboard for the coming edge, then advance.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input issue_beat_t exp, input logic ordy, input logic fl);
        logic acc;
        u_in.in_valid   = v;
        u_in.instr      = ins;
        u_in.rs_data    = rs;
        u_in.rt_data    = rt;
        u_out.out_ready = ordy;
        flush           = fl;
        check({tag, ".out_valid"}, u_out.out_valid, exp_q.size() != 0);
        check({tag, ".in_ready"},  u_in.in_ready,   exp_q.size() < 2);
        if (exp_q.size() != 0) check({tag, ".beat"}, dut_beat(), exp_q[0]);
        acc = v && (exp_q.size() < 2);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(exp);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic ordy);
        step(tag, 1'b1, ins, rs, rt, ref_decode(ins, rs, rt), ordy, 1'b0);
    endtask

    task automatic idle(input string tag, input logic ordy);
        step(tag, 1'b0, 32'h0, 32'h0, 32'h0, '0, ordy, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fn_list [10];
        logic [4:0] rd;
        logic [31:0] w;
        fn_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
        rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        w  = $urandom;
        case ($urandom_range(0, 6))
            0, 1: w = {6'h00, w[25:16], rd, w[10:6], fn_list[$urandom_range(0, 9)]};
            2:    w = {6'h00, w[25:6], 6'b10100 + 6'($urandom_range(0, 1)) * 6'd0 + 6'($urandom_range(0, 1))};
            3:    w = {6'($urandom_range(8, 14)), w[25:21], rd, w[15:0]};
            4:    w = {6'h23, w[25:21], rd, w[15:0]};
            5:    w = {6'h2b, w[25:0]};
            default: w = {6'($urandom_range(15, 63)), w[25:0]};
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        u_in.in_valid   = 1'b0;
        u_in.instr      = '0;
        u_in.rs_data    = '0;
        u_in.rt_data    = '0;
        u_out.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst.out_valid", u_out.out_valid, 1'b0);
        check("rst.in_ready",  u_in.in_ready,   1'b1);
        check("rst.beat",      dut_beat(),      '0);
        rst = 1'b0;
        @(negedge clk);

        // Directed decodes from fixed expected values.
        step("add",  1'b1, 32'h00221820, 32'd5, 32'd7,
             mk(4'b0000, 32'd5, 32'd7, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0), 1'b1, 1'b0);
        step("ori",  1'b1, 32'h3424FFFF, 32'd0, 32'd9,
             mk(4'b1101, 32'd0, 32'h0000FFFF, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 1'b0), 1'b1, 1'b0);
        step("slti", 1'b1, 32'h2824FFFF, 32'h11, 32'd9,
             mk(4'b1010, 32'h11, 32'hFFFFFFFF, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 1'b0), 1'b1, 1'b0);
        step("sw",   1'b1, 32'hAC22FFFC, 32'h100, 32'hDEADBEEF,
             mk(4'b0000, 32'h100, 32'hFFFFFFFC, 1'b0, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0), 1'b1, 1'b0);
        step("lui",  1'b1, 32'h3C01ABCD, 32'h3, 32'h4,
             mk(4'b0000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b1, 1'b0);
        step("nop",  1'b1, 32'h00000000, 32'h3, 32'h4, '0, 1'b1, 1'b0);
        step("lw",   1'b1, 32'h8C450010, 32'h200, 32'h1,
             mk(4'b0000, 32'h200, 32'h10, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0), 1'b1, 1'b0);
        step("add_r0", 1'b1, 32'h00220020, 32'd1, 32'd2,
             mk(4'b0000, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0), 1'b1, 1'b0);
        step("fn_28", 1'b1, 32'h00221828, 32'd1, 32'd2,
             mk(4'b0000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b1, 1'b0);
        idle("drain0", 1'b1);
        idle("drain1", 1'b1);

        // Stall: A held, B in skid, C refused until space opens; then in order.
        send("stall_a", 32'h00221820, 32'hA, 32'h1, 1'b0);
        send("stall_b", 32'h00432022, 32'hB, 32'h2, 1'b0);
        repeat (3) send("stall_c", 32'h3465000F, 32'hC, 32'h3, 1'b0);
        send("resume_c0", 32'h3465000F, 32'hC, 32'h3, 1'b1);
        send("resume_c1", 32'h3465000F, 32'hC, 32'h3, 1'b1);
        repeat (3) idle("resume_drain", 1'b1);

        // Flush with two beats held and a new beat offered at the same edge.
        send("fl_d", 32'h00221825, 32'hD, 32'h4, 1'b0);
        send("fl_e", 32'h00221826, 32'hE, 32'h5, 1'b0);
        step("fl_f", 1'b1, 32'h00221827, 32'hF, 32'h6, ref_decode(32'h00221827, 32'hF, 32'h6), 1'b0, 1'b1);
        idle("post_flush", 1'b1);

        // Asynchronous reset with two beats held.
        send("rr_a", 32'h00221821, 32'h21, 32'h1, 1'b0);
        send("rr_b", 32'h00221823, 32'h22, 32'h2, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst.out_valid", u_out.out_valid, 1'b0);
        check("midrst.in_ready",  u_in.in_ready,   1'b1);
        check("midrst.beat",      dut_beat(),      '0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle("post_rst", 1'b1);

        // Random traffic with random back-pressure.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] w;
            logic [31:0] rs;
            logic [31:0] rt;
            w  = rand_instr();
            rs = $urandom;
            rt = $urandom;
            step("rand", ($urandom_range(0, 3) != 0), w, rs, rt, ref_decode(w, rs, rt),
                 ($urandom_range(0, 2) != 0), 1'b0);
        end
        repeat (4) idle("final_drain", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
